// File: rtl/pci_in_decoder.sv
// pci_in_decoder: PCI target address decoder and data-beat extractor; define PCI_IN_PARITY_EN to add bus parity checking
module pci_in_decoder (
  input  logic        PHY_CLK33_I,
  input  logic        PHY_RST_I,
  input  logic        FRAMEn_I,
  input  logic        IRDYn_I,
  input  logic        TRDYn_I,
  input  logic        STOPn_I,
  input  logic        IDSEL_I,
  input  logic [31:0] AD_I,
  input  logic [3:0]  CBEn_I,
  input  logic        PAR_I,
  input  logic [31:0] BAR_I,
  input  logic [31:0] BAR_MASK_I,
  input  logic        MEM_SPACE_EN_I,
  output logic        CFG_OUTPUT_EN_O,
  output logic        MEM_OUTPUT_EN_O,
  output logic [31:0] ADDR_O,
  output logic [3:0]  CMD_O,
  output logic        WR_O,
  output logic        BEAT_O,
  output logic [31:0] DATA_O,
  output logic [3:0]  BE_O,
  output logic        LAST_O,
  output logic        PERR_O
);
  typedef enum logic [1:0] {IDLE, DATA, MISS, TURN} state_t;
  state_t state;
  logic frame_q, armed;
  logic addr_phase, xfer, abort, cfg_hit, mem_hit;
  // armed blocks decoding until FRAME# has been seen high after reset, so a FRAME# held low through reset is not taken as a fresh edge
  always_comb begin
    addr_phase = (state == IDLE || state == TURN) && !FRAMEn_I && IRDYn_I && frame_q && armed;
    xfer       = state == DATA && !IRDYn_I && !TRDYn_I;
    abort      = state == DATA && FRAMEn_I && !IRDYn_I && !STOPn_I && TRDYn_I;
    cfg_hit    = CBEn_I[3:1] == 3'b101 && IDSEL_I && AD_I[1:0] == 2'b00;
    mem_hit    = CBEn_I inside {4'h6, 4'h7, 4'hC, 4'hE, 4'hF} && MEM_SPACE_EN_I &&
                 (AD_I & BAR_MASK_I) == (BAR_I & BAR_MASK_I);
  end
  // transaction state machine with registered outputs
  always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
    if (PHY_RST_I) begin
      state           <= IDLE;
      frame_q         <= 1'b1;
      armed           <= 1'b0;
      CFG_OUTPUT_EN_O <= 1'b0;
      MEM_OUTPUT_EN_O <= 1'b0;
      ADDR_O          <= '0;
      CMD_O           <= '0;
      WR_O            <= 1'b0;
      BEAT_O          <= 1'b0;
      DATA_O          <= '0;
      BE_O            <= '0;
      LAST_O          <= 1'b0;
    end else begin
      frame_q <= FRAMEn_I;
      armed   <= armed | FRAMEn_I;
      BEAT_O  <= 1'b0;
      LAST_O  <= 1'b0;
      case (state)
        IDLE, TURN: begin
          state <= addr_phase ? ((cfg_hit || mem_hit) ? DATA : MISS) : IDLE;
          if (addr_phase) begin
            ADDR_O          <= AD_I;
            CMD_O           <= CBEn_I;
            WR_O            <= CBEn_I[0];
            CFG_OUTPUT_EN_O <= cfg_hit;
            MEM_OUTPUT_EN_O <= mem_hit;
          end
        end
        DATA: begin
          if (xfer) begin
            BEAT_O <= 1'b1;
            DATA_O <= AD_I;
            BE_O   <= ~CBEn_I;
            LAST_O <= FRAMEn_I;
            ADDR_O <= ADDR_O + 32'd4;
          end
          if ((xfer && FRAMEn_I) || abort) begin
            state           <= TURN;
            CFG_OUTPUT_EN_O <= 1'b0;
            MEM_OUTPUT_EN_O <= 1'b0;
          end
        end
        MISS: state <= (FRAMEn_I && IRDYn_I) ? IDLE : MISS;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PCI_IN_PARITY_EN
  logic par_pend, par_exp;
  // PAR arrives one clock after the AD/CBE it covers, so hold the expected value for one cycle
  always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
    if (PHY_RST_I) begin
      par_pend <= 1'b0;
      par_exp  <= 1'b0;
      PERR_O   <= 1'b0;
    end else begin
      par_pend <= addr_phase || xfer;
      par_exp  <= ^{AD_I, CBEn_I};
      PERR_O   <= par_pend && (PAR_I != par_exp);
    end
  end
`else
  logic unused_par;
  assign unused_par = PAR_I;
  assign PERR_O     = 1'b0;
`endif
endmodule

// File: tb/tb_pci_in_decoder.sv
// tb_pci_in_decoder: scoreboard bench for pci_in_decoder with directed bus vectors
module tb_pci_in_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_n = 1'b0, irdy_n = 1'b1, trdy_n = 1'b1, stop_n = 1'b1;
  logic        idsel = 1'b1;
  logic [31:0] ad = '0;
  logic [3:0]  cbe = 4'hA;
  logic        par = 1'b0;
  logic [31:0] bar = 32'hF000_0000, bar_mask = 32'hFFFF_0000;
  logic        mem_en = 1'b1;
  logic        cfg_oe, mem_oe, wr, beat, last, perr;
  logic [31:0] addr, data;
  logic [3:0]  cmd, be;
  typedef struct {logic [31:0] d; logic [3:0] be; logic last; logic [31:0] a;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, perr_n = 0;
  logic bad_par = 1'b0;

  pci_in_decoder dut (
    .PHY_CLK33_I(clk), .PHY_RST_I(rst), .FRAMEn_I(frame_n), .IRDYn_I(irdy_n),
    .TRDYn_I(trdy_n), .STOPn_I(stop_n), .IDSEL_I(idsel), .AD_I(ad), .CBEn_I(cbe),
    .PAR_I(par), .BAR_I(bar), .BAR_MASK_I(bar_mask), .MEM_SPACE_EN_I(mem_en),
    .CFG_OUTPUT_EN_O(cfg_oe), .MEM_OUTPUT_EN_O(mem_oe), .ADDR_O(addr), .CMD_O(cmd),
    .WR_O(wr), .BEAT_O(beat), .DATA_O(data), .BE_O(be), .LAST_O(last), .PERR_O(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one bus cycle at negedge; PAR covers the previous cycle's AD/CBE
  task automatic cyc(input logic f, i, t, s, input logic [31:0] a, input logic [3:0] c);
    @(negedge clk);
    par     = ^{ad, cbe} ^ bad_par;
    bad_par = 1'b0;
    frame_n = f; irdy_n = i; trdy_n = t; stop_n = s; ad = a; cbe = c;
    @(posedge clk);
    #2;
  endtask

  task automatic xfer(input logic f, input logic [31:0] a, input logic [3:0] c, input logic [31:0] next_addr);
    q.push_back('{a, ~c, f, next_addr});
    cyc(f, 1'b0, 1'b0, 1'b1, a, c);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 4'hF);
  endtask

  // monitor: every beat must match the oldest expected beat
  always @(posedge clk) begin
    #1;
    if (perr) perr_n++;
    if (beat) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat: data %h addr %h", data, addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("beat_data", data, e.d);
        chk("beat_be", {28'h0, be}, {28'h0, e.be});
        chk("beat_last", {31'h0, last}, {31'h0, e.last});
        chk("beat_addr", addr, e.a);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cfg", {31'h0, cfg_oe}, 0);
    chk("rst_mem", {31'h0, mem_oe}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_cmd", {28'h0, cmd}, 0);
    @(negedge clk) rst = 1'b0;
    // FRAME# held low across reset release must not decode
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 4'hA);
    chk("no_decode_after_rst", {31'h0, cfg_oe}, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 4'hA);
    chk("no_decode_after_rst2", {31'h0, cfg_oe}, 0);
    idle(); idle();
    // config read, single beat
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 4'hA);
    chk("cfg_oe", {31'h0, cfg_oe}, 1);
    chk("cfg_mem_oe", {31'h0, mem_oe}, 0);
    chk("cfg_cmd", {28'h0, cmd}, 32'hA);
    chk("cfg_wr", {31'h0, wr}, 0);
    chk("cfg_addr", addr, 32'h10);
    xfer(1'b1, 32'hDEAD_BEEF, 4'h0, 32'h14);
    chk("cfg_turn_oe", {31'h0, cfg_oe}, 0);
    idle();
    idsel = 1'b0;
    // memory burst write with one wait state and a parity error on beat 1
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hF000_0FF8, 4'h7);
    chk("mem_oe", {31'h0, mem_oe}, 1);
    chk("mem_cfg_oe", {31'h0, cfg_oe}, 0);
    chk("mem_wr", {31'h0, wr}, 1);
    chk("mem_cmd", {28'h0, cmd}, 32'h7);
    chk("mem_addr", addr, 32'hF000_0FF8);
    xfer(1'b0, 32'hA1A1_A1A1, 4'h0, 32'hF000_0FFC);
    bad_par = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h5555_5555, 4'h0);
    chk("wait_addr", addr, 32'hF000_0FFC);
    chk("wait_oe", {31'h0, mem_oe}, 1);
    xfer(1'b0, 32'hA2A2_A2A2, 4'h3, 32'hF000_1000);
    xfer(1'b0, 32'hA3A3_A3A3, 4'h0, 32'hF000_1004);
    xfer(1'b1, 32'hA4A4_A4A4, 4'h0, 32'hF000_1008);
    chk("mem_turn_oe", {31'h0, mem_oe}, 0);
    idle();
    // miss: activity inside MISS produces nothing
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_0000, 4'h6);
    chk("miss_mem_oe", {31'h0, mem_oe}, 0);
    chk("miss_cfg_oe", {31'h0, cfg_oe}, 0);
    chk("miss_cmd", {28'h0, cmd}, 32'h6);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 4'h7);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hF000_0004, 4'h7);
    chk("miss_hold_oe", {31'h0, mem_oe}, 0);
    idle();
    // wrap, disconnect, then fast back-to-back config cycle from TURN
    bar = 32'hFFFF_0000;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 4'h6);
    chk("wrap_oe", {31'h0, mem_oe}, 1);
    xfer(1'b0, 32'hB1B1_B1B1, 4'h0, 32'h0000_0000);
    chk("wrap_addr", addr, 32'h0);
    xfer(1'b0, 32'hB2B2_B2B2, 4'h0, 32'h0000_0004);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
    chk("disc_oe", {31'h0, mem_oe}, 0);
    chk("disc_last", {31'h0, last}, 0);
    idsel = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 4'hB);
    chk("b2b_cfg_oe", {31'h0, cfg_oe}, 1);
    chk("b2b_cmd", {28'h0, cmd}, 32'hB);
    chk("b2b_wr", {31'h0, wr}, 1);
    xfer(1'b1, 32'hC0C0_C0C0, 4'h5, 32'h24);
    idle();
    idsel = 1'b0;
    bar = 32'hF000_0000;
    // reset asserted mid-burst clears outputs immediately
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hF000_0100, 4'h7);
    xfer(1'b0, 32'hD1D1_D1D1, 4'h0, 32'hF000_0104);
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b0; trdy_n = 1'b0; ad = 32'hD2D2_D2D2;
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_beat", {31'h0, beat}, 0);
    chk("rst_mid_oe", {31'h0, mem_oe}, 0);
    chk("rst_mid_addr", addr, 0);
    chk("rst_mid_cmd", {28'h0, cmd}, 0);
    chk("rst_mid_wr", {31'h0, wr}, 0);
    @(negedge clk);
    frame_n = 1'b1; irdy_n = 1'b1; trdy_n = 1'b1;
    rst = 1'b0;
    idle(); idle();
    chk("queue_empty", q.size(), 0);
`ifdef PCI_IN_PARITY_EN
    chk("perr_count", perr_n, 1);
`else
    chk("perr_count", perr_n, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pci_in_decoder.md
PCI_IN_DECODER -- requirements
Module: pci_in_decoder

Interface
REQ-001 SHALL have the following ports, one per line as name, direction, width, meaning.
REQ-002 PHY_CLK33_I  in  1  PCI 33 MHz clock; all state on rising edge.
REQ-003 PHY_RST_I  in  1  reset, asynchronous, active-high.
REQ-004 FRAMEn_I  in  1  bus FRAME#, active-low.
REQ-005 IRDYn_I  in  1  bus IRDY#, active-low.
REQ-006 TRDYn_I  in  1  bus TRDY#, active-low, as driven by the output encoder.
REQ-007 STOPn_I  in  1  bus STOP#, active-low, as driven by the output encoder.
REQ-008 IDSEL_I  in  1  configuration select.
REQ-009 AD_I  in  32  multiplexed address/data.
REQ-010 CBEn_I  in  4  command (address phase) or byte enables (data phase), active-low.
REQ-011 PAR_I  in  1  even parity over AD_I/CBEn_I, one clock late; ignored unless PCI_IN_PARITY_EN.
REQ-012 BAR_I  in  32  memory base address.
REQ-013 BAR_MASK_I  in  32  address bits compared against BAR_I (1 = compare).
REQ-014 MEM_SPACE_EN_I  in  1  command-register memory enable.
REQ-015 CFG_OUTPUT_EN_O  out  1  configuration target owns transaction.
REQ-016 MEM_OUTPUT_EN_O  out  1  memory target owns transaction.
REQ-017 ADDR_O  out  32  current beat address.
REQ-018 CMD_O  out  4  latched bus command.
REQ-019 WR_O  out  1  latched command is a write (CMD bit0 = 1).
REQ-020 BEAT_O  out  1  one-cycle strobe: data transfer completed.
REQ-021 DATA_O  out  32  AD_I captured on the transfer; valid with BEAT_O.
REQ-022 BE_O  out  4  ~CBEn_I captured on the transfer; active-high.
REQ-023 LAST_O  out  1  qualifies BEAT_O as the final beat.
REQ-024 PERR_O  out  1  one-cycle parity-error strobe.

Function
REQ-025 SHALL implement the states IDLE, DATA, MISS and TURN, with all outputs registered.
REQ-026 SHALL detect an address phase in IDLE or TURN when FRAMEn_I=0, IRDYn_I=1 and FRAMEn_I was 1 in the previous cycle; on detection, latch AD_I to ADDR_O and CBEn_I to CMD_O.
REQ-027 SHALL decode a configuration hit when CMD is 0xA or 0xB, IDSEL_I=1 and AD_I[1:0]=00.
REQ-028 SHALL decode a memory hit when CMD is in {0x6,0x7,0xC,0xE,0xF}, MEM_SPACE_EN_I=1 and (AD_I & BAR_MASK_I)==(BAR_I & BAR_MASK_I).
REQ-029 SHALL, on a hit, go to DATA and assert the matching *_OUTPUT_EN_O the clock after the address phase (latency 1); cfg and mem enables are never asserted together.
REQ-030 SHALL, on no hit, go to MISS with both enables 0; MISS returns to IDLE when FRAMEn_I=1 and IRDYn_I=1.
REQ-031 SHALL, in DATA, count a transfer when IRDYn_I=0 and TRDYn_I=0, and pulse BEAT_O the next cycle with DATA_O and BE_O.
REQ-032 SHALL advance ADDR_O by 4 after each transfer, wrapping modulo 2^32.
REQ-033 SHALL end a DATA transaction, setting LAST_O on that beat and moving to TURN, when a transfer occurs with FRAMEn_I=1.
REQ-034 SHALL also end a DATA transaction and move to TURN when FRAMEn_I=1, IRDYn_I=0 and STOPn_I=0 without a transfer (disconnect/abort), in which case BEAT_O is not pulsed.
REQ-035 SHALL leave DATA state unchanged and emit no BEAT_O during wait states (IRDYn_I=1 or TRDYn_I=1).
REQ-036 SHALL, in TURN, deassert both enables and go to IDLE after 1 cycle, unless a fast back-to-back address phase (REQ-026) is detected, which is decoded as from IDLE.
REQ-037 SHALL ignore AD_I/CBEn_I changes in MISS.

Reset
REQ-038 SHALL, while PHY_RST_I=1 (asynchronously, including mid-transaction), force state IDLE, all outputs 0, ADDR_O=0, CMD_O=0 and the previous-FRAMEn register=1.
REQ-039 SHALL, after reset release, decode nothing until a fresh FRAMEn_I falling edge.

Configuration
REQ-040 SHALL, with PCI_IN_PARITY_EN defined, compute even parity of AD_I and CBEn_I on each address phase and transfer, compare it with PAR_I one clock later, and pulse PERR_O one cycle on mismatch.
REQ-041 SHALL, without PCI_IN_PARITY_EN, contain no parity logic, hold PERR_O at 0 and leave PAR_I unused.

Verification
REQ-042 Config read: IDSEL=1, CBEn=0xA, AD=0x00000010 -> CFG_OUTPUT_EN_O=1 next clock, CMD_O=0xA, WR_O=0; one beat with FRAMEn=1 -> BEAT_O, LAST_O=1, then TURN, then IDLE.
REQ-043 Memory burst write: BAR=0xF000_0000, mask=0xFFFF_0000, AD=0xF000_0FF8, CBEn=0x7, 4 beats with one TRDY wait state -> 4 BEAT_O pulses, ADDR_O 0x...FF8/FFC/1000/1004, LAST_O on beat 4 only.
REQ-044 Miss: AD=0x1234_0000 with the same BAR -> both enables stay 0, state MISS until FRAMEn=IRDYn=1, no BEAT_O.
REQ-045 Wrap and disconnect: AD=0xFFFF_FFFC hit, 2 beats -> ADDR_O wraps to 0x0000_0000; STOPn=0, FRAMEn=1, no transfer -> TURN with no BEAT_O.
REQ-046 Reset mid-burst: PHY_RST_I=1 during beat 2 -> all outputs 0 immediately; PARITY_EN build: wrong PAR_I on beat 1 -> PERR_O pulses exactly once.
